fx2_slavefifo_ctrl: RTL and testbench
=====================================

Name: fx2_slavefifo_ctrl

Overview:
- FPGA-side master for the FX2 slave-FIFO bus (ifclk domain).
- Drains host command bytes from EP2 (OUT, fifoadr 2'b00) into a downstream command stream.
- Pushes an upstream data byte stream into EP6 (IN, fifoadr 2'b10), arbitrating the shared fd bus between both directions.
- Commits short packets with pktend.

Parameters:
- WR_BURST, 16: max consecutive EP6 writes before a pending EP2 read is granted the bus.
- IDLE_TIMEOUT, 1024: idle cycles before an auto-pktend, used only with FX2_AUTO_PKTEND_EN.
- TMR_W, 11: width of the idle timer; must hold IDLE_TIMEOUT.

Ports:
- ifclk  input  1  interface clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fd  inout  8  FX2 data bus; driven only while writing, otherwise Z.
- slrd  output  1  FX2 read strobe, active-low.
- slwr  output  1  FX2 write strobe, active-low.
- sloe  output  1  FX2 output enable, active-low.
- fifoadr  output  2  FX2 endpoint select.
- pktend  output  1  FX2 packet commit, active-low.
- flags  input  3  FX2 flags, active-low: [0]=EP2 empty, [1]=EP6 full, [2] unused.
- cmd_data  output  8  byte read from EP2.
- cmd_valid  output  1  one-cycle pulse; cmd_data is valid.
- cmd_ready  input  1  downstream can accept one byte.
- data_in  input  8  byte to send to EP6.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  byte consumed this cycle (valid&ready handshake).
- flush  input  1  one-cycle pulse requesting a pktend.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): slrd=slwr=sloe=pktend=1, fifoadr=00, fd=Z, cmd_valid=0, data_ready=0, cmd_data=0, busy=0, state IDLE, burst count 0, pending_pkt 0, flush latch 0, timer 0. Asserting reset mid-transfer deasserts all strobes immediately. A byte in flight is lost and not reported.
- Request terms:
  - rd_req = flags[0] & cmd_ready.
  - wr_req = data_valid & flags[1].
- Flags are sampled only in IDLE and WR_GAP; each strobe is followed by at least one settle cycle.
- State machine, one state per cycle:
  - IDLE:
    - rd_req -> RD_OE.
    - else wr_req -> WR_ADDR.
    - else (flush latch | auto timeout) & pending_pkt -> PKT_ADDR.
    - Read wins over write when both are requested in IDLE.
  - RD_OE: fifoadr=00, sloe=0 -> RD_STROBE.
  - RD_STROBE: sloe=0, slrd=0; cmd_data<=fd at cycle end -> RD_DONE.
  - RD_DONE: sloe=0, cmd_valid=1 -> IDLE.
  - Read latency: rd_req in IDLE to cmd_valid is 3 cycles.
  - WR_ADDR: fifoadr=10, fd still Z, burst<=0 -> WR_STROBE.
  - WR_STROBE: fd=data_in, slwr=0, data_ready=1; burst+1; pending_pkt<=1 -> WR_GAP.
  - WR_GAP: fd=Z, fifoadr=10.
    - wr_req & burst<WR_BURST & !(rd_req & burst==WR_BURST) -> WR_STROBE.
    - else -> IDLE.
    - Sustained write rate: one byte per 2 cycles.
  - PKT_ADDR: fifoadr=10 -> PKT_STROBE.
  - PKT_STROBE: pktend=0 -> PKT_GAP.
  - PKT_GAP: clear pending_pkt, flush latch and timer -> IDLE.
- Flush handling:
  - flush is latched in any state and served at the next IDLE with no rd_req/wr_req.
  - flush with pending_pkt=0 is discarded; no zero-length packet is sent.
- data_ready is 0 in every state except WR_STROBE.
- cmd_valid is never asserted unless cmd_ready was high in the IDLE cycle that started the read.
- fd is never driven in any state where sloe=0.
- slrd, slwr and pktend are never low in the same cycle.
- fifoadr changes only on the IDLE->*_OE/*_ADDR transition and the return to IDLE.

Optional Feature:
- FX2_AUTO_PKTEND_EN defined:
  - The timer counts each IDLE cycle while pending_pkt=1 and no request is present.
  - The timer resets on any write.
  - The timer saturates at IDLE_TIMEOUT, which triggers PKT_ADDR as if flush were latched.
- Not defined: no timer logic; pktend is issued only via flush.

Test Plan:
- Reset: assert reset_n=0 mid WR_STROBE -> slwr=1, fd=Z, fifoadr=00 with no clock edge; after release, busy=0.
- Read: EP2 holds bytes 0xA5, 0x3C, cmd_ready=1 -> cmd_valid pulses deliver 0xA5 then 0x3C, each 3 cycles after IDLE, then flags[0]=0 and reads stop.
- Backpressure: EP2 non-empty, cmd_ready=0 for 20 cycles -> slrd and sloe stay 1; cmd_ready=1 -> first cmd_valid 3 cycles later.
- Write burst with arbitration (WR_BURST=16): 40-byte stream 0x00..0x27, EP2 non-empty from start -> 16 bytes 0x00..0x0F written, then one EP2 read, then the rest resumes in order with no duplicates or drops.
- Full stall: flags[1] driven 0 after byte 5 -> no slwr and data_ready=0 until flags[1]=1; byte 6 follows with no loss.
- Flush: write 3 bytes then pulse flush -> exactly one pktend=0 cycle with fifoadr=10. A second flush with nothing written -> no pktend. With FX2_AUTO_PKTEND_EN and IDLE_TIMEOUT=8, 3 bytes then idle -> pktend fires once after 8 idle cycles.

Source files
------------

// File: rtl/fx2_slavefifo_ctrl.sv
// fx2_slavefifo_ctrl: FPGA-side master for the FX2 slave-FIFO bus.
// Reads host command bytes from EP2 and writes an upstream byte stream into EP6.
// Both directions share fd. Short packets are committed with pktend.
// Optional macro FX2_AUTO_PKTEND_EN adds an idle timer that commits a pending
// packet without an explicit flush.
module fx2_slavefifo_ctrl #(
    parameter int WR_BURST     = 16,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TMR_W        = 11
) (
    input  logic       ifclk,
    input  logic       reset_n,
    inout  wire  [7:0] fd,
    output logic       slrd,
    output logic       slwr,
    output logic       sloe,
    output logic [1:0] fifoadr,
    output logic       pktend,
    input  logic [2:0] flags,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic       flush,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, RD_OE, RD_STROBE, RD_DONE,
        WR_ADDR, WR_STROBE, WR_GAP,
        PKT_ADDR, PKT_STROBE, PKT_GAP
    } state_t;

    localparam int BW = $clog2(WR_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(WR_BURST);

    state_t          state, state_nxt;
    logic [BW-1:0]   burst;
    logic            pending_pkt;
    logic            flush_lat;
    logic            fd_oe;
    logic            timeout;
    logic            rd_req, wr_req;
    logic            unused_flag;

    // flags are active-low: flags[0]=1 means EP2 has data, flags[1]=1 means EP6 has room
    assign rd_req      = flags[0] & cmd_ready;
    assign wr_req      = data_valid & flags[1];
    assign unused_flag = flags[2];

    assign fd   = fd_oe ? data_in : 8'hzz;
    assign busy = (state != IDLE);

`ifdef FX2_AUTO_PKTEND_EN
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(IDLE_TIMEOUT);
    logic [TMR_W-1:0] tmr;

    assign timeout = (tmr == TMR_MAX);

    // Idle timer: counts quiet IDLE cycles with uncommitted data, saturates at the limit
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n)
            tmr <= '0;
        else if (state == WR_STROBE || state == PKT_GAP)
            tmr <= '0;
        else if (state == IDLE && pending_pkt && !rd_req && !wr_req && !timeout)
            tmr <= tmr + 1'b1;
    end
`else
    localparam int unused_tmr_cfg = IDLE_TIMEOUT + TMR_W;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and strobe decode; every strobe is a single state so it lasts one cycle
    always_comb begin
        state_nxt  = state;
        slrd       = 1'b1;
        slwr       = 1'b1;
        sloe       = 1'b1;
        pktend     = 1'b1;
        fifoadr    = 2'b00;
        fd_oe      = 1'b0;
        cmd_valid  = 1'b0;
        data_ready = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req)                                     state_nxt = RD_OE;
                else if (wr_req)                                state_nxt = WR_ADDR;
                else if ((flush_lat | timeout) && pending_pkt) state_nxt = PKT_ADDR;
            end
            RD_OE: begin
                sloe      = 1'b0;
                state_nxt = RD_STROBE;
            end
            RD_STROBE: begin
                sloe      = 1'b0;
                slrd      = 1'b0;
                state_nxt = RD_DONE;
            end
            RD_DONE: begin
                sloe      = 1'b0;
                cmd_valid = 1'b1;
                state_nxt = IDLE;
            end
            WR_ADDR: begin
                fifoadr   = 2'b10;
                state_nxt = WR_STROBE;
            end
            WR_STROBE: begin
                fifoadr    = 2'b10;
                fd_oe      = 1'b1;
                slwr       = 1'b0;
                data_ready = 1'b1;
                state_nxt  = WR_GAP;
            end
            WR_GAP: begin
                fifoadr = 2'b10;
                // a full burst always yields to IDLE so a waiting EP2 read gets the bus
                if (wr_req && burst < BURST_MAX && !(rd_req && burst == BURST_MAX))
                    state_nxt = WR_STROBE;
                else
                    state_nxt = IDLE;
            end
            PKT_ADDR: begin
                fifoadr   = 2'b10;
                state_nxt = PKT_STROBE;
            end
            PKT_STROBE: begin
                fifoadr   = 2'b10;
                pktend    = 1'b0;
                state_nxt = PKT_GAP;
            end
            PKT_GAP: begin
                fifoadr   = 2'b10;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst count, packet-pending and flush latch bookkeeping
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            burst       <= '0;
            pending_pkt <= 1'b0;
            flush_lat   <= 1'b0;
        end else begin
            if (state == WR_ADDR)        burst <= '0;
            else if (state == WR_STROBE) burst <= burst + 1'b1;

            if (state == WR_STROBE)    pending_pkt <= 1'b1;
            else if (state == PKT_GAP) pending_pkt <= 1'b0;

            // a flush seen with nothing to commit is dropped so no zero-length packet goes out
            if (state == PKT_GAP)
                flush_lat <= 1'b0;
            else if (state == IDLE && !rd_req && !wr_req && !pending_pkt)
                flush_lat <= flush;
            else if (flush)
                flush_lat <= 1'b1;
        end
    end

    // Capture the EP2 byte at the end of the read strobe
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n)                cmd_data <= 8'h00;
        else if (state == RD_STROBE) cmd_data <= fd;
    end

endmodule

// File: tb/tb_fx2_slavefifo_ctrl.sv
// Testbench for fx2_slavefifo_ctrl: behavioural FX2 (EP2 source queue, EP6 sink),
// a byte source on data_in, and an event scoreboard checked by a monitor.
module tb_fx2_slavefifo_ctrl;

    logic       ifclk = 1'b0;
    logic       reset_n = 1'b1;
    wire  [7:0] fd;
    logic       slrd, slwr, sloe, pktend;
    logic [1:0] fifoadr;
    logic [2:0] flags;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       flush = 1'b0;
    logic       busy;

    int checks = 0;
    int failures = 0;

    // expected events: {kind, byte}; kind 1=EP6 write, 2=cmd byte, 3=pktend (byte = fifoadr)
    logic [9:0] exp_q[$];

    logic [7:0] ep2_q[$];
    logic       ep2_ne = 1'b0;
    logic [7:0] ep2_head = 8'h00;
    bit         rd_seen = 1'b0;
    logic       ep6_nf = 1'b1;

    logic [7:0] src_q[$];
    bit         took = 1'b0;
    bit         src_drop = 1'b0;

`ifdef FX2_AUTO_PKTEND_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    assign flags = {1'b1, ep6_nf, ep2_ne};
    assign fd    = (!sloe) ? ep2_head : 8'hzz;

    always #5 ifclk = ~ifclk;

    fx2_slavefifo_ctrl #(.WR_BURST(16), .IDLE_TIMEOUT(8), .TMR_W(4)) dut (
        .ifclk(ifclk), .reset_n(reset_n), .fd(fd), .slrd(slrd), .slwr(slwr),
        .sloe(sloe), .fifoadr(fifoadr), .pktend(pktend), .flags(flags),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .flush(flush), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic ev(input logic [1:0] k, input logic [7:0] v);
        logic [9:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=%0d:%02h required=none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e !== {k, v}) begin
                failures++;
                $display("FAIL event actual=%0d:%02h required=%0d:%02h", k, v, e[9:8], e[7:0]);
            end
        end
    endtask

    // EP2 model: the byte leaves the FIFO one cycle after the read strobe
    always @(negedge ifclk) begin
        logic [7:0] tmp;
        if (rd_seen) begin
            if (ep2_q.size() > 0) tmp = ep2_q.pop_front();
            rd_seen = 1'b0;
        end
        if (reset_n && !slrd) rd_seen = 1'b1;
        ep2_ne   = (ep2_q.size() != 0);
        ep2_head = ep2_ne ? ep2_q[0] : 8'h00;
    end

    // Byte source: a byte is retired one cycle after its valid&ready cycle
    always @(negedge ifclk) begin
        logic [7:0] tmp;
        bit         t;
        t = data_valid && data_ready;
        if (src_drop) begin
            src_q.delete();
            t = 1'b0;
        end else if (took) begin
            tmp = src_q.pop_front();
        end
        took       = t;
        data_valid = (src_q.size() != 0);
        data_in    = data_valid ? src_q[0] : 8'h00;
    end

    // Monitor: every DUT-presented event is popped against the scoreboard
    always @(negedge ifclk) begin
        int nlow;
        if (reset_n) begin
            if (!slwr)     ev(2'd1, fd);
            if (cmd_valid) ev(2'd2, cmd_data);
            if (!pktend)   ev(2'd3, {6'b0, fifoadr});
            nlow = (slrd ? 0 : 1) + (slwr ? 0 : 1) + (pktend ? 0 : 1);
            chk("strobe_exclusive", (nlow <= 1), 1);
            chk("data_ready_vs_slwr", data_ready, !slwr);
        end
    end

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 16 && n < 2000) begin
            @(negedge ifclk);
            n++;
            if (!busy && src_q.size() == 0 && !took) q++;
            else q = 0;
        end
        chk("quiet_timeout", (q >= 16), 1);
    endtask

    task automatic pulse_flush();
        @(posedge ifclk); #1 flush = 1'b1;
        @(posedge ifclk); #1 flush = 1'b0;
    endtask

    task automatic lat_to_valid(output int lat);
        lat = 0;
        do begin
            @(posedge ifclk); #1;
            lat++;
        end while (!cmd_valid && lat < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        bit found;
        bit ok;

        // reset values, before any clock edge
        #1 reset_n = 1'b0;
        #2;
        chk("rst_strobes", {slrd, slwr, sloe, pktend}, 4'hF);
        chk("rst_fifoadr", fifoadr, 0);
        chk("rst_outs", {cmd_valid, data_ready, busy}, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_fd_z", (fd === 8'hzz), 1);
        repeat (3) @(posedge ifclk);
        #1 reset_n = 1'b1;

        // reset asserted in the middle of the second write strobe
        exp_q.push_back({2'd1, 8'hE0});
        src_q.push_back(8'hE0);
        src_q.push_back(8'hE1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge ifclk); #1;
            if (!slwr && fd == 8'hE1) found = 1'b1;
        end
        chk("wait_e1_strobe", found, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_slwr", slwr, 1);
        chk("midrst_fd_z", (fd === 8'hzz), 1);
        chk("midrst_fifoadr", fifoadr, 0);
        chk("midrst_data_ready", data_ready, 0);
        src_drop = 1'b1;
        @(negedge ifclk);
        @(negedge ifclk);
        src_drop = 1'b0;
        @(posedge ifclk); #1 reset_n = 1'b1;
        @(posedge ifclk); #1;
        chk("post_rst_busy", busy, 0);

        // reset cleared pending_pkt, so this flush must not produce a pktend
        pulse_flush();
        wait_quiet();

        // two command bytes; latency from the IDLE cycle, then the next one
        cmd_ready = 1'b0;
        ep2_q.push_back(8'hA5);
        ep2_q.push_back(8'h3C);
        exp_q.push_back({2'd2, 8'hA5});
        exp_q.push_back({2'd2, 8'h3C});
        repeat (2) @(posedge ifclk);
        #1 cmd_ready = 1'b1;
        lat_to_valid(lat);
        chk("rd_latency_first", lat, 3);
        lat_to_valid(lat);
        chk("rd_spacing_second", lat, 4);
        repeat (10) @(posedge ifclk);
        #1 chk("rd_stopped_slrd", slrd, 1);

        // backpressure: EP2 non-empty but downstream not ready
        cmd_ready = 1'b0;
        ep2_q.push_back(8'h5A);
        exp_q.push_back({2'd2, 8'h5A});
        ok = 1'b1;
        repeat (20) begin
            @(negedge ifclk);
            if (!slrd || !sloe) ok = 1'b0;
        end
        chk("bp_no_strobe", ok, 1);
        @(posedge ifclk); #1 cmd_ready = 1'b1;
        lat_to_valid(lat);
        chk("bp_latency", lat, 3);
        wait_quiet();

        // burst arbitration: 16 writes, one read, then the rest of the stream
        cmd_ready = 1'b0;
        ep2_q.push_back(8'h77);
        for (int i = 0; i < 16; i++) exp_q.push_back({2'd1, 8'(i)});
        exp_q.push_back({2'd2, 8'h77});
        for (int i = 16; i < 40; i++) exp_q.push_back({2'd1, 8'(i)});
        if (AUTO) exp_q.push_back({2'd3, 8'h02});
        @(negedge ifclk);
        for (int i = 0; i < 40; i++) src_q.push_back(8'(i));
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge ifclk);
            if (!slwr) found = 1'b1;
        end
        chk("arb_first_write", found, 1);
        cmd_ready = 1'b1;
        wait_quiet();

        // EP6 goes full after byte 0x85; nothing is written until it drains
        for (int i = 0; i < 6; i++) exp_q.push_back({2'd1, 8'(8'h80 + i)});
        if (AUTO) exp_q.push_back({2'd3, 8'h02});
        for (int i = 6; i < 10; i++) exp_q.push_back({2'd1, 8'(8'h80 + i)});
        if (AUTO) exp_q.push_back({2'd3, 8'h02});
        for (int i = 0; i < 10; i++) src_q.push_back(8'(8'h80 + i));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge ifclk);
            if (!slwr && fd == 8'h85) found = 1'b1;
        end
        chk("stall_saw_85", found, 1);
        ep6_nf = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge ifclk);
            if (!slwr || data_ready) ok = 1'b0;
        end
        chk("stall_no_write", ok, 1);
        ep6_nf = 1'b1;
        wait_quiet();

`ifdef FX2_AUTO_PKTEND_EN
        // three bytes then silence: the timer counts 8 idle cycles, the next IDLE commits
        for (int i = 0; i < 3; i++) exp_q.push_back({2'd1, 8'(8'h50 + i)});
        exp_q.push_back({2'd3, 8'h02});
        for (int i = 0; i < 3; i++) src_q.push_back(8'(8'h50 + i));
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge ifclk);
            if (!pktend)    found = 1'b1;
            else if (!slwr) cnt = 0;
            else if (!busy) cnt++;
        end
        chk("auto_pktend_seen", found, 1);
        chk("auto_idle_cycles", cnt, 9);
        wait_quiet();
`else
        // three bytes, flush -> exactly one pktend cycle; a second flush -> nothing
        for (int i = 0; i < 3; i++) exp_q.push_back({2'd1, 8'(8'h50 + i)});
        for (int i = 0; i < 3; i++) src_q.push_back(8'(8'h50 + i));
        wait_quiet();
        exp_q.push_back({2'd3, 8'h02});
        pulse_flush();
        cnt = 0;
        repeat (20) begin
            @(negedge ifclk);
            if (!pktend) cnt++;
        end
        chk("flush_pktend_count", cnt, 1);
        pulse_flush();
        cnt = 0;
        repeat (20) begin
            @(negedge ifclk);
            if (!pktend) cnt++;
        end
        chk("flush_empty_no_pktend", cnt, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
